// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-cache request/response bus between fetch and the I-cache
interface fetch_stage_if;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_data;

    modport master (
        output ic_req,
        output ic_addr,
        input  ic_valid,
        input  ic_data
    );

    modport slave (
        input  ic_req,
        input  ic_addr,
        output ic_valid,
        output ic_data
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, single outstanding I-cache request, IF/ID register
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [5:0]  OP_STALL = 6'h3F
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    fetch_stage_if.master       ic,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc4,
    output logic                if_valid
);

    localparam logic [31:0] BUBBLE_INSTR = {OP_STALL, 26'b0};

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic [31:0] pc_plus4;

    // FULL parks the request: the skid already holds the next instruction
    assign ic.ic_req  = (state == FETCH || state == DRAIN) && !reset;
    assign ic.ic_addr = req_addr;
    assign pc_plus4   = pc + 32'd4;

    // Fetch FSM and IF/ID register; branch flush beats stall beats normal flow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= PC_RESET;
            req_addr   <= PC_RESET;
            skid_instr <= BUBBLE_INSTR;
            skid_pc4   <= 32'd0;
            if_instr   <= BUBBLE_INSTR;
            if_pc4     <= 32'd0;
            if_valid   <= 1'b0;
        end else if (branch_taken) begin
            pc       <= branch_target;
            if_instr <= BUBBLE_INSTR;
            if_pc4   <= 32'd0;
            if_valid <= 1'b0;
            // An unanswered request must be drained before the target can be issued
            if (state != FULL && !ic.ic_valid) begin
                state <= DRAIN;
            end else begin
                state    <= FETCH;
                req_addr <= branch_target;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (ic.ic_valid) begin
                        pc <= pc_plus4;
                        if (stall) begin
                            // Decode cannot take it yet: park the response in the skid
                            skid_instr <= ic.ic_data;
                            skid_pc4   <= pc_plus4;
                            state      <= FULL;
                        end else begin
                            if_instr <= ic.ic_data;
                            if_pc4   <= pc_plus4;
                            if_valid <= 1'b1;
                            req_addr <= pc_plus4;
                        end
                    end else if (!stall) begin
                        if_instr <= BUBBLE_INSTR;
                        if_pc4   <= 32'd0;
                        if_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        if_instr <= skid_instr;
                        if_pc4   <= skid_pc4;
                        if_valid <= 1'b1;
                        req_addr <= pc;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    // The stale response is dropped; pc already holds the redirect target
                    if_instr <= BUBBLE_INSTR;
                    if_pc4   <= 32'd0;
                    if_valid <= 1'b0;
                    if (ic.ic_valid) begin
                        req_addr <= pc;
                        state    <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven scoreboard bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] B = 32'hFC00_0000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_valid;

    fetch_stage_if bus ();

    fetch_stage #(
        .PC_RESET (32'h0000_0000),
        .OP_STALL (6'h3F)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ic            (bus.master),
        .if_instr      (if_instr),
        .if_pc4        (if_pc4),
        .if_valid      (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          st;
        bit          br;
        logic [31:0] tgt;
        bit          icv;
        bit          req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        bit          val;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        bit          val;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rst, bit st, bit br, logic [31:0] tgt, bit icv,
                                bit req, logic [31:0] addr,
                                logic [31:0] instr, logic [31:0] pc4, bit val);
        vec_t v;
        v.rst = rst; v.st = st; v.br = br; v.tgt = tgt; v.icv = icv;
        v.req = req; v.addr = addr; v.instr = instr; v.pc4 = pc4; v.val = val;
        return v;
    endfunction

    task automatic do_reset();
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        bus.ic_valid  = 1'b0;
        bus.ic_data   = JUNK;
        @(posedge clk);
        #1;
        chk("rst_ic_req",   {31'd0, bus.ic_req}, 32'd0);
        chk("rst_ic_addr",  bus.ic_addr, 32'd0);
        chk("rst_if_instr", if_instr, B);
        chk("rst_if_pc4",   if_pc4, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic step(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        stall         = v.st;
        branch_taken  = v.br;
        branch_target = v.tgt;
        bus.ic_valid  = v.icv;
        bus.ic_data   = v.icv ? v.addr : JUNK;
        #1;
        chk($sformatf("v%0d_ic_req", idx),  {31'd0, bus.ic_req}, {31'd0, v.req});
        chk($sformatf("v%0d_ic_addr", idx), bus.ic_addr, v.addr);
        e.instr = v.instr; e.pc4 = v.pc4; e.val = v.val;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk($sformatf("v%0d_if_instr", idx), if_instr, got.instr);
        chk($sformatf("v%0d_if_pc4", idx),   if_pc4, got.pc4);
        chk($sformatf("v%0d_if_valid", idx), {31'd0, if_valid}, {31'd0, got.val});
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        bus.ic_valid  = 1'b0;
        bus.ic_data   = JUNK;

        //                rst st br tgt            icv req addr           instr          pc4            val
        // consecutive hits, ic_data = address
        tbl.push_back(mk(1, 0, 0, 32'h0,         1,  1, 32'h0,         32'h0,         32'h4,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h4,         32'h4,         32'h8,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h8,         32'h8,         32'hC,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'hC,         32'hC,         32'h10,        1));
        // 3-cycle miss at 8, then branch to 100 during a miss at C
        tbl.push_back(mk(1, 0, 0, 32'h0,         1,  1, 32'h0,         32'h0,         32'h4,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h4,         32'h4,         32'h8,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0,  1, 32'h8,         B,             32'h0,         0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0,  1, 32'h8,         B,             32'h0,         0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0,  1, 32'h8,         B,             32'h0,         0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h8,         32'h8,         32'hC,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0,  1, 32'hC,         B,             32'h0,         0));
        tbl.push_back(mk(0, 0, 1, 32'h100,       0,  1, 32'hC,         B,             32'h0,         0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0,  1, 32'hC,         B,             32'h0,         0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'hC,         B,             32'h0,         0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h100,       32'h100,       32'h104,       1));
        // stall while response for 4 arrives, skid drain, branch+stall with full skid
        tbl.push_back(mk(1, 0, 0, 32'h0,         1,  1, 32'h0,         32'h0,         32'h4,         1));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1,  1, 32'h4,         32'h0,         32'h4,         1));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1,  0, 32'h4,         32'h0,         32'h4,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0,  0, 32'h4,         32'h4,         32'h8,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h8,         32'h8,         32'hC,         1));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1,  1, 32'hC,         32'h8,         32'hC,         1));
        tbl.push_back(mk(0, 1, 1, 32'h200,       1,  0, 32'hC,         B,             32'h0,         0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h200,       32'h200,       32'h204,       1));
        // wrap at the top of the address space
        tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 1,  1, 32'h204,       B,             32'h0,         0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h0,         32'h0,         32'h4,         1));
        // stall with no response holds IF/ID; unaligned target passes through
        tbl.push_back(mk(0, 1, 0, 32'h0,         0,  1, 32'h4,         32'h0,         32'h4,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h4,         32'h4,         32'h8,         1));
        tbl.push_back(mk(0, 0, 1, 32'h302,       1,  1, 32'h8,         B,             32'h0,         0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1,  1, 32'h302,       32'h302,       32'h306,       1));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i], i);
        end

        // reset asserted mid-miss abandons the request asynchronously
        do_reset();
        step(mk(0, 0, 0, 32'h0, 1, 1, 32'h0, 32'h0, 32'h4, 1), 100);
        bus.ic_valid = 1'b0;
        bus.ic_data  = JUNK;
        #1;
        chk("midmiss_req_before", {31'd0, bus.ic_req}, 32'd1);
        chk("midmiss_addr_before", bus.ic_addr, 32'h4);
        reset = 1'b1;
        #1;
        chk("midmiss_req_async",   {31'd0, bus.ic_req}, 32'd0);
        chk("midmiss_valid_async", {31'd0, if_valid}, 32'd0);
        chk("midmiss_instr_async", if_instr, B);
        chk("midmiss_addr_async",  bus.ic_addr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(mk(0, 0, 0, 32'h0, 1, 1, 32'h0, 32'h0, 32'h4, 1), 101);
        step(mk(0, 0, 0, 32'h0, 1, 1, 32'h4, 32'h4, 32'h8, 1), 102);

        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
